// File: rtl/nv_nvdla_car_rst_seq.sv
// Partition reset sequencer: releases partition resets in ascending order, with a programmable
// gap and a per-step ack timeout, and tears them down in descending order.
module nv_nvdla_car_rst_seq #(
    parameter int NUM_PART = 4,
    parameter int GAP_W    = 8,
    parameter int TO_W     = 12,
    parameter int IDX_W    = 2
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                seq_en,
    input  logic [GAP_W-1:0]    cfg_gap,
    input  logic [TO_W-1:0]     cfg_timeout,
    input  logic [NUM_PART-1:0] part_ack_sync,
    output logic [NUM_PART-1:0] part_rstn_o,
    output logic                seq_busy,
    output logic                seq_done,
    output logic                seq_err,
    output logic [IDX_W-1:0]    err_part
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GAP      = 3'd1;
    localparam logic [2:0] S_REL_WAIT = 3'd2;
    localparam logic [2:0] S_UP       = 3'd3;
    localparam logic [2:0] S_DOWN     = 3'd4;
    localparam logic [2:0] S_ERR      = 3'd5;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PART - 1);

    logic [2:0]          state, state_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [GAP_W-1:0]    gap_cnt, gap_cnt_nxt;
    logic [TO_W-1:0]     to_cnt, to_cnt_nxt;
    logic                to_en, to_en_nxt;
    logic [NUM_PART-1:0] rstn_nxt;
    logic                seq_err_nxt;
    logic [IDX_W-1:0]    err_part_nxt;
    logic                go_down;
    logic [IDX_W-1:0]    down_idx;
    logic                ack_cur;
    logic                to_expired;

    // Timeout is armed only when the value loaded at step start was non-zero.
    assign ack_cur    = part_ack_sync[idx];
    assign to_expired = to_en && (to_cnt == '0);

    // NOTE: every variable gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        gap_cnt_nxt  = gap_cnt;
        to_cnt_nxt   = to_cnt;
        to_en_nxt    = to_en;
        rstn_nxt     = part_rstn_o;
        seq_err_nxt  = seq_err;
        err_part_nxt = err_part;
        go_down      = 1'b0;
        down_idx     = idx;

        case (state)
            S_IDLE: begin
                if (seq_en) begin
                    state_nxt    = S_GAP;
                    idx_nxt      = '0;
                    gap_cnt_nxt  = cfg_gap;
                    seq_err_nxt  = 1'b0;
                    err_part_nxt = '0;
                end
            end
            S_GAP: begin
                if (!seq_en) begin
                    go_down = 1'b1;
                end else if (gap_cnt == '0) begin
                    state_nxt     = S_REL_WAIT;
                    rstn_nxt[idx] = 1'b1;
                    to_cnt_nxt    = cfg_timeout;
                    to_en_nxt     = |cfg_timeout;
                end else begin
                    gap_cnt_nxt = gap_cnt - GAP_W'(1);
                end
            end
            S_REL_WAIT: begin
                if (!seq_en) begin
                    go_down = 1'b1;
                end else if (ack_cur) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = S_UP;
                    end else begin
                        state_nxt   = S_GAP;
                        idx_nxt     = idx + IDX_W'(1);
                        gap_cnt_nxt = cfg_gap;
                    end
                end else if (to_expired) begin
                    state_nxt    = S_ERR;
                    seq_err_nxt  = 1'b1;
                    err_part_nxt = idx;
                end else if (to_en) begin
                    to_cnt_nxt = to_cnt - TO_W'(1);
                end
            end
            S_UP, S_ERR: begin
                if (!seq_en) go_down = 1'b1;
            end
            S_DOWN: begin
                // seq_en is deliberately ignored here: teardown always runs to IDLE.
                if (!ack_cur) begin
                    if (idx == '0) begin
                        state_nxt = S_IDLE;
                    end else begin
                        go_down  = 1'b1;
                        down_idx = idx - IDX_W'(1);
                    end
                end else if (to_expired) begin
                    state_nxt    = S_ERR;
                    seq_err_nxt  = 1'b1;
                    err_part_nxt = idx;
                end else if (to_en) begin
                    to_cnt_nxt = to_cnt - TO_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Every entry into DOWN asserts the reset of the step's partition and restarts its timeout.
        if (go_down) begin
            state_nxt          = S_DOWN;
            idx_nxt            = down_idx;
            rstn_nxt[down_idx] = 1'b0;
            to_cnt_nxt         = cfg_timeout;
            to_en_nxt          = |cfg_timeout;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= S_IDLE;
            idx         <= '0;
            gap_cnt     <= '0;
            to_cnt      <= '0;
            to_en       <= 1'b0;
            part_rstn_o <= '0;
            seq_busy    <= 1'b0;
            seq_done    <= 1'b0;
            seq_err     <= 1'b0;
            err_part    <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            gap_cnt     <= gap_cnt_nxt;
            to_cnt      <= to_cnt_nxt;
            to_en       <= to_en_nxt;
            part_rstn_o <= rstn_nxt;
            seq_busy    <= (state_nxt == S_GAP) || (state_nxt == S_REL_WAIT) || (state_nxt == S_DOWN);
            seq_done    <= (state_nxt == S_UP);
            seq_err     <= seq_err_nxt;
            err_part    <= err_part_nxt;
        end
    end
endmodule

// File: tb/tb_nv_nvdla_car_rst_seq.sv
// Bench for nv_nvdla_car_rst_seq: vector table, hand-written abort/reset sequences and random
// stimulus, all compared each cycle against a step-count model of the sequencing rules.
module tb_nv_nvdla_car_rst_seq;
    localparam int NP = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          seq_en;
    logic [7:0]    cfg_gap;
    logic [11:0]   cfg_timeout;
    logic [NP-1:0] ack;
    logic [NP-1:0] part_rstn_o;
    logic          seq_busy;
    logic          seq_done;
    logic          seq_err;
    logic [1:0]    err_part;

    always #5 clk = ~clk;

    nv_nvdla_car_rst_seq #(.NUM_PART(NP), .GAP_W(8), .TO_W(12), .IDX_W(2)) dut (
        .i_clk        (clk),
        .i_rstn       (rst_n),
        .seq_en       (seq_en),
        .cfg_gap      (cfg_gap),
        .cfg_timeout  (cfg_timeout),
        .part_ack_sync(ack),
        .part_rstn_o  (part_rstn_o),
        .seq_busy     (seq_busy),
        .seq_done     (seq_done),
        .seq_err      (seq_err),
        .err_part     (err_part)
    );

    typedef enum int {M_OFF, M_GAPWAIT, M_ACKWAIT, M_ALLUP, M_TEARDOWN, M_FAULT} mode_t;

    typedef struct {
        logic          en;
        int            gap;
        int            to;
        int            dly;
        logic [NP-1:0] slo;
        int            cycles;
        logic [NP-1:0] e_rstn;
        logic          e_busy;
        logic          e_done;
        logic          e_err;
        int            e_part;
    } vec_t;

    mode_t         m_mode;
    logic [NP-1:0] m_rstn;
    int            m_pos, m_elapsed, m_gap_len, m_limit, m_err_part;
    logic          m_err;

    int            n_total = 0;
    int            n_bad   = 0;
    int            ack_delay;
    logic [NP-1:0] stuck_lo, stuck_hi;
    logic [NP-1:0] hist[$];
    logic [NP-1:0] prev_rstn;
    vec_t          vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts elapsed cycles per step and compares them against the latched limits.
    function automatic void model_reset();
        m_mode     = M_OFF;
        m_rstn     = '0;
        m_pos      = 0;
        m_elapsed  = 0;
        m_gap_len  = 0;
        m_limit    = 0;
        m_err      = 1'b0;
        m_err_part = 0;
    endfunction

    function automatic void start_down(input int p, input int to);
        m_mode    = M_TEARDOWN;
        m_pos     = p;
        m_rstn[p] = 1'b0;
        m_elapsed = 0;
        m_limit   = to;
    endfunction

    function automatic void fault();
        m_mode     = M_FAULT;
        m_err      = 1'b1;
        m_err_part = m_pos;
    endfunction

    function automatic void model_step(input logic en, input int gap, input int to, input logic [NP-1:0] a);
        case (m_mode)
            M_OFF: if (en) begin
                m_mode = M_GAPWAIT; m_pos = 0; m_elapsed = 0; m_gap_len = gap;
                m_err = 1'b0; m_err_part = 0;
            end
            M_GAPWAIT: begin
                if (!en) start_down(m_pos, to);
                else if (m_elapsed == m_gap_len) begin
                    m_rstn[m_pos] = 1'b1; m_mode = M_ACKWAIT; m_elapsed = 0; m_limit = to;
                end else m_elapsed++;
            end
            M_ACKWAIT: begin
                if (!en) start_down(m_pos, to);
                else if (a[m_pos]) begin
                    if (m_pos == NP - 1) m_mode = M_ALLUP;
                    else begin m_pos++; m_elapsed = 0; m_gap_len = gap; m_mode = M_GAPWAIT; end
                end else if (m_limit != 0 && m_elapsed == m_limit) fault();
                else m_elapsed++;
            end
            M_TEARDOWN: begin
                if (!a[m_pos]) begin
                    if (m_pos == 0) m_mode = M_OFF;
                    else start_down(m_pos - 1, to);
                end else if (m_limit != 0 && m_elapsed == m_limit) fault();
                else m_elapsed++;
            end
            M_ALLUP, M_FAULT: if (!en) start_down(m_pos, to);
            default: m_mode = M_OFF;
        endcase
    endfunction

    function automatic void fill_hist();
        hist.delete();
        repeat (301) hist.push_front(part_rstn_o);
        ack       = (part_rstn_o & ~stuck_lo) | stuck_hi;
        prev_rstn = part_rstn_o;
    endfunction

    // Each partition acks its reset level ack_delay cycles later, unless forced.
    task automatic drive_ack();
        hist.push_front(part_rstn_o);
        if (hist.size() > 301) void'(hist.pop_back());
        ack = (hist[ack_delay] & ~stuck_lo) | stuck_hi;
    endtask

    task automatic compare_all();
        check("part_rstn", 32'(part_rstn_o), 32'(m_rstn));
        check("seq_busy", 32'(seq_busy), 32'(m_mode inside {M_GAPWAIT, M_ACKWAIT, M_TEARDOWN}));
        check("seq_done", 32'(seq_done), 32'(m_mode == M_ALLUP));
        check("seq_err", 32'(seq_err), 32'(m_err));
        check("err_part", 32'(err_part), 32'(m_err_part));
        check("one_bit_step", ($countones(part_rstn_o ^ prev_rstn) <= 1) ? 32'd1 : 32'd0, 32'd1);
        check("done_err_excl", 32'(seq_done & seq_err), 32'd0);
        prev_rstn = part_rstn_o;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step(seq_en, int'(cfg_gap), int'(cfg_timeout), ack);
        @(negedge clk);
        compare_all();
        drive_ack();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NP-1:0] seen[$];
        logic [NP-1:0] last;
        logic [NP-1:0] exp_a[3];
        int            c;

        vecs[0] = '{1'b1, 3, 10, 2,   4'b0000, 40,  4'b1111, 1'b0, 1'b1, 1'b0, 0};
        vecs[1] = '{1'b0, 3, 10, 2,   4'b0000, 30,  4'b0000, 1'b0, 1'b0, 1'b0, 0};
        vecs[2] = '{1'b1, 1, 5,  2,   4'b0100, 40,  4'b0111, 1'b0, 1'b0, 1'b1, 2};
        vecs[3] = '{1'b0, 1, 5,  2,   4'b0100, 20,  4'b0000, 1'b0, 1'b0, 1'b1, 2};
        vecs[4] = '{1'b1, 0, 0,  200, 4'b0000, 900, 4'b1111, 1'b0, 1'b1, 1'b0, 0};
        vecs[5] = '{1'b0, 0, 0,  1,   4'b0000, 20,  4'b0000, 1'b0, 1'b0, 1'b0, 0};
        exp_a[0] = 4'b0011; exp_a[1] = 4'b0001; exp_a[2] = 4'b0000;

        rst_n = 1'b1; seq_en = 1'b0; cfg_gap = '0; cfg_timeout = '0; ack = '0;
        stuck_lo = '0; stuck_hi = '0; ack_delay = 0; prev_rstn = '0;
        model_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_rstn", 32'(part_rstn_o), 32'd0);
        check("reset_busy", 32'(seq_busy), 32'd0);
        check("reset_done", 32'(seq_done), 32'd0);
        check("reset_err", 32'(seq_err), 32'd0);
        check("reset_err_part", 32'(err_part), 32'd0);
        fill_hist();
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            cfg_gap     = 8'(vecs[i].gap);
            cfg_timeout = 12'(vecs[i].to);
            stuck_lo    = vecs[i].slo;
            stuck_hi    = '0;
            ack_delay   = vecs[i].dly;
            fill_hist();
            seq_en = vecs[i].en;
            repeat (vecs[i].cycles) cycle();
            check($sformatf("vec%0d_rstn", i), 32'(part_rstn_o), 32'(vecs[i].e_rstn));
            check($sformatf("vec%0d_busy", i), 32'(seq_busy), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_done", i), 32'(seq_done), 32'(vecs[i].e_done));
            check($sformatf("vec%0d_err", i), 32'(seq_err), 32'(vecs[i].e_err));
            check($sformatf("vec%0d_err_part", i), 32'(err_part), 32'(vecs[i].e_part));
        end

        // Abort while waiting on partition 2: resets fall one at a time, highest first.
        cfg_gap = 8'd1; cfg_timeout = 12'd0; stuck_lo = 4'b0100; ack_delay = 2;
        fill_hist();
        seq_en = 1'b1;
        repeat (20) cycle();
        check("abort_pre_rstn", 32'(part_rstn_o), 32'(4'b0111));
        check("abort_pre_busy", 32'(seq_busy), 32'd1);
        seq_en = 1'b0;
        last = part_rstn_o;
        c = 0;
        while (c < 40 && !(seq_busy == 1'b0 && part_rstn_o == '0)) begin
            cycle();
            if (part_rstn_o != last) begin
                seen.push_back(part_rstn_o);
                last = part_rstn_o;
            end
            c++;
        end
        check("abort_steps", 32'(seen.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            if (k < seen.size()) check($sformatf("abort_step%0d", k), 32'(seen[k]), 32'(exp_a[k]));
        check("abort_idle_busy", 32'(seq_busy), 32'd0);

        // Asynchronous reset mid-GAP with partitions 0 and 1 up.
        cfg_gap = 8'd12; stuck_lo = '0; ack_delay = 1;
        fill_hist();
        seq_en = 1'b1;
        c = 0;
        while (c < 200 && part_rstn_o != 4'b0011) begin
            cycle();
            c++;
        end
        check("midgap_reach", 32'(part_rstn_o), 32'(4'b0011));
        repeat (5) cycle();
        check("midgap_busy", 32'(seq_busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rstn", 32'(part_rstn_o), 32'd0);
        check("async_busy", 32'(seq_busy), 32'd0);
        check("async_done", 32'(seq_done), 32'd0);
        check("async_err", 32'(seq_err), 32'd0);
        check("async_err_part", 32'(err_part), 32'd0);
        model_reset();
        fill_hist();
        #1 rst_n = 1'b1;
        repeat (100) cycle();
        check("post_reset_done", 32'(seq_done), 32'd1);
        check("post_reset_rstn", 32'(part_rstn_o), 32'(4'b1111));

        // Random enable toggling, config changes mid-count and stuck acks.
        for (int r = 0; r < 3000; r++) begin
            if ($urandom_range(0, 39) == 0) begin
                seq_en   = ~seq_en;
                stuck_lo = '0;
                stuck_hi = '0;
                if ($urandom_range(0, 3) == 0) stuck_lo[$urandom_range(0, NP - 1)] = 1'b1;
                else if ($urandom_range(0, 5) == 0) stuck_hi[$urandom_range(0, NP - 1)] = 1'b1;
                ack_delay = $urandom_range(0, 6);
            end
            if ($urandom_range(0, 15) == 0) begin
                cfg_gap     = 8'($urandom_range(0, 5));
                cfg_timeout = 12'($urandom_range(0, 8));
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
